// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle RV32I control FSM with illegal-op and memory-timeout traps
module mc_ctrl #(
  parameter int ALUOP_W = 5,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         Op,
  input  logic [6:0]         Funct7,
  input  logic [2:0]         Funct3,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [2:0]         EXTOp,
  output logic [1:0]         PCSrc,
  output logic [2:0]         DMType,
  output logic [1:0]         WDSel,
  output logic [2:0]         state,
  output logic               illegal,
  output logic               timeout
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5
  } state_t;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(6);

  state_t     cur;
  logic [7:0] cnt;
  logic       ill_q, to_q;

  logic is_r, is_i, is_ld, is_st, is_br, is_jal, legal, at_limit;
  logic [ALUOP_W-1:0] alu_funct;
  logic [2:0]         dm_funct;

  assign is_r   = (Op == 7'b0110011);
  assign is_i   = (Op == 7'b0010011);
  assign is_ld  = (Op == 7'b0000011);
  assign is_st  = (Op == 7'b0100011);
  assign is_br  = (Op == 7'b1100011);
  assign is_jal = (Op == 7'b1101111);

  assign legal =
      (is_r && ((Funct7 == 7'b0000000 && Funct3 inside {3'b000, 3'b110, 3'b111}) ||
                (Funct7 == 7'b0100000 && Funct3 == 3'b000))) ||
      (is_i  && Funct3 inside {3'b000, 3'b110, 3'b111}) ||
      (is_ld && Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
      (is_st && Funct3 inside {3'b000, 3'b001, 3'b010}) ||
      (is_br && Funct3 inside {3'b000, 3'b001}) ||
      is_jal;

  assign at_limit = (cnt == 8'(TIMEOUT - 1));

  always_comb begin
    alu_funct = ALU_ADD;
    case (Funct3)
      3'b000:  alu_funct = (is_r && Funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b110:  alu_funct = ALU_OR;
      3'b111:  alu_funct = ALU_AND;
      default: alu_funct = ALU_ADD;
    endcase
  end

  always_comb begin
    dm_funct = 3'b000;
    case (Funct3)
      3'b000:  dm_funct = 3'b011;
      3'b001:  dm_funct = 3'b001;
      3'b100:  dm_funct = 3'b100;
      3'b101:  dm_funct = 3'b010;
      default: dm_funct = 3'b000;
    endcase
  end

  // Counter is zeroed on every transition so each wait window starts fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur   <= S_FETCH;
      cnt   <= 8'd0;
      ill_q <= 1'b0;
      to_q  <= 1'b0;
    end else begin
      case (cur)
        S_FETCH: begin
          if (mem_ready) begin
            cur <= S_DECODE;
            cnt <= 8'd0;
          end else if (at_limit) begin
            cur  <= S_TRAP;
            cnt  <= 8'd0;
            to_q <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DECODE: begin
          cnt <= 8'd0;
          if (!legal) begin
            cur   <= S_TRAP;
            ill_q <= 1'b1;
          end else begin
            cur <= S_EXEC;
          end
        end
        S_EXEC: begin
          cnt <= 8'd0;
          if (is_ld || is_st)    cur <= S_MEM;
          else if (is_r || is_i) cur <= S_WB;
          else                   cur <= S_FETCH;
        end
        S_MEM: begin
          if (mem_ready) begin
            cur <= is_ld ? S_WB : S_FETCH;
            cnt <= 8'd0;
          end else if (at_limit) begin
            cur  <= S_TRAP;
            cnt  <= 8'd0;
            to_q <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_WB: begin
          cur <= S_FETCH;
          cnt <= 8'd0;
        end
        S_TRAP:  cur <= S_TRAP;
        default: cur <= S_TRAP;
      endcase
    end
  end

  always_comb begin
    PCWrite = 1'b0; IRWrite = 1'b0; IorD = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    RegWrite = 1'b0; ALUSrcA = 2'b00; ALUSrcB = 2'b00; ALUOp = '0; EXTOp = 3'b000;
    PCSrc = 2'b00; DMType = 3'b000; WDSel = 2'b00;
    state = 3'd0; illegal = 1'b0; timeout = 1'b0;
    if (!rst) begin
      state   = cur;
      illegal = ill_q;
      timeout = to_q;
      case (cur)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          ALUOp   = ALU_ADD;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b10;
          ALUOp   = ALU_ADD;
          EXTOp   = is_jal ? 3'b100 : 3'b011;
        end
        S_EXEC: begin
          if (is_r) begin
            ALUSrcA = 2'b01;
            ALUOp   = alu_funct;
          end else if (is_i) begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            EXTOp   = 3'b001;
            ALUOp   = alu_funct;
          end else if (is_ld || is_st) begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            EXTOp   = is_st ? 3'b010 : 3'b001;
            ALUOp   = ALU_ADD;
          end else if (is_br) begin
            ALUSrcA = 2'b01;
            ALUOp   = ALU_SUB;
            PCSrc   = 2'b01;
            PCWrite = Funct3[0] ? ~Zero : Zero;
          end else if (is_jal) begin
            RegWrite = 1'b1;
            WDSel    = 2'b10;
            PCWrite  = 1'b1;
            PCSrc    = 2'b01;
          end
        end
        S_MEM: begin
          IorD     = 1'b1;
          DMType   = dm_funct;
          MemRead  = is_ld;
          MemWrite = is_st;
        end
        S_WB: begin
          RegWrite = 1'b1;
          WDSel    = is_ld ? 2'b01 : 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule
